// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Arbitrates two requesters (A = core LSU, B = debug/DMA) onto one
//   single-ported data memory with a combinational read path. Every
//   transaction takes two cycles: an IDLE cycle that grants a port and latches
//   its request, then an ACCESS cycle that reads memory and, for writes, writes
//   back a byte-merged word. Completion (rvalid/rdata/err) is registered and
//   appears in the following IDLE cycle. That same cycle can grant the next
//   request, so back-to-back transactions run at one per two cycles.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_*, we_*, addr_*,          per-port request; held until gnt_* pulses
//   wdata_*, be_*
//   gnt_*                         one-cycle accept pulse (combinational in IDLE)
//   rvalid_*, rdata_*, err_*      registered completion; err = out of range
//   mem_we, mem_raddr, mem_waddr, data_memory write/address/data, zero
//   mem_wdata                     outside ACCESS
//   mem_rdata                     asynchronous read data from data_memory
module data_mem_arbiter #(
    parameter int MEM_SIZE = 1024,
    parameter int RR_EN    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        we_a,
    input  logic [31:0] addr_a,
    input  logic [31:0] wdata_a,
    input  logic [3:0]  be_a,
    input  logic        req_b,
    input  logic        we_b,
    input  logic [31:0] addr_b,
    input  logic [31:0] wdata_b,
    input  logic [3:0]  be_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        rvalid_a,
    output logic        rvalid_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    output logic        err_a,
    output logic        err_b,
    output logic        mem_we,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam bit          RR    = (RR_EN != 0);
    localparam logic [32:0] LIMIT = 33'(MEM_SIZE) << 2;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t      state;
    req_t        cur;
    req_t        win;
    logic        owner_b;
    logic        last_b;
    logic        pick_b;
    logic        in_range;
    logic        access;
    logic [31:0] merged;

    // Byte-offset bits are deliberately ignored: all accesses are whole words.
    logic unused_lsb;
    assign unused_lsb = &{1'b0, addr_a[1:0], addr_b[1:0]};

    // B wins when it is the only requester, or on a tie when round-robin is
    // on and A was the last owner. Otherwise A wins.
    assign pick_b = req_b && (!req_a || (RR && !last_b));

    assign gnt_a = !rst && (state == IDLE) && req_a && !pick_b;
    assign gnt_b = !rst && (state == IDLE) && pick_b;

    always_comb begin
        win = '0;
        if (pick_b)
            win = '{we: we_b, addr: {addr_b[31:2], 2'b00}, wdata: wdata_b, be: be_b};
        else
            win = '{we: we_a, addr: {addr_a[31:2], 2'b00}, wdata: wdata_a, be: be_a};
    end

    assign in_range = ({1'b0, cur.addr} < LIMIT);

    // Gating with rst keeps a reset in the ACCESS cycle from writing memory.
    assign access = (state == ACCESS) && !rst;

    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = cur.be[i] ? cur.wdata[8*i +: 8] : mem_rdata[8*i +: 8];
    end

    assign mem_raddr = access ? cur.addr : 32'h0;
    assign mem_waddr = access ? cur.addr : 32'h0;
    assign mem_wdata = access ? merged : 32'h0;
    assign mem_we    = access && cur.we && in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur      <= '0;
            owner_b  <= 1'b0;
            last_b   <= 1'b1;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            err_a    <= 1'b0;
            err_b    <= 1'b0;
            rdata_a  <= 32'h0;
            rdata_b  <= 32'h0;
        end else begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            err_a    <= 1'b0;
            err_b    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        cur     <= win;
                        owner_b <= pick_b;
                        last_b  <= pick_b;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= IDLE;
                    if (owner_b) begin
                        rvalid_b <= 1'b1;
                        err_b    <= !in_range;
                        if (!in_range)
                            rdata_b <= 32'h0;
                        else if (!cur.we)
                            rdata_b <= mem_rdata;
                    end else begin
                        rvalid_a <= 1'b1;
                        err_a    <= !in_range;
                        if (!in_range)
                            rdata_a <= 32'h0;
                        else if (!cur.we)
                            rdata_a <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [31:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
    logic [3:0]  be_a = '0, be_b = '0;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, mem_we;
    logic [31:0] rdata_a, rdata_b, mem_raddr, mem_waddr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:1023];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_raddr[11:2]];
    always @(posedge clk) if (mem_we) mem[mem_waddr[11:2]] <= mem_wdata;

    data_mem_arbiter #(.MEM_SIZE(1024), .RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .be_a(be_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .be_b(be_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .err_a(err_a), .err_b(err_b),
        .mem_we(mem_we), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Advance to just after the next rising edge; inputs are driven here and
    // outputs sampled #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
        step(); #1;
        n_cmp++; if (gnt_a !== 1'b0) begin n_fail++; $display("FAIL rst_gnt_a got %b want 0", gnt_a); end
        n_cmp++; if (gnt_b !== 1'b0) begin n_fail++; $display("FAIL rst_gnt_b got %b want 0", gnt_b); end
        n_cmp++; if ({rvalid_a, rvalid_b, err_a, err_b} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got %b want 0000", {rvalid_a, rvalid_b, err_a, err_b}); end
        n_cmp++; if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h/%h want 0/0", rdata_a, rdata_b); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        req_a = 1'b0; req_b = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_read();
        mem[1] = 32'h1;
        step(); req_a = 1'b1; we_a = 1'b0; addr_a = 32'h4; #1;
        n_cmp++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin n_fail++; $display("FAIL read_gnt got %b%b want 10", gnt_a, gnt_b); end
        step(); req_a = 1'b0; #1;
        n_cmp++; if (mem_raddr !== 32'h4) begin n_fail++; $display("FAIL read_raddr got %h want 00000004", mem_raddr); end
        n_cmp++; if (mem_we !== 1'b0 || rvalid_a !== 1'b0) begin n_fail++; $display("FAIL read_access got we=%b rv=%b want 0 0", mem_we, rvalid_a); end
        step(); #1;
        n_cmp++; if (rvalid_a !== 1'b1 || err_a !== 1'b0) begin n_fail++; $display("FAIL read_rvalid got rv=%b err=%b want 1 0", rvalid_a, err_a); end
        n_cmp++; if (rdata_a !== 32'h1) begin n_fail++; $display("FAIL read_rdata got %h want 00000001", rdata_a); end
        step(); #1;
        n_cmp++; if (rvalid_a !== 1'b0 || rdata_a !== 32'h1) begin n_fail++; $display("FAIL read_hold got rv=%b rdata=%h want 0 00000001", rvalid_a, rdata_a); end
        n_cmp++; if (mem_raddr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL idle_mem_bus got %h/%h want 0/0", mem_raddr, mem_wdata); end
    endtask

    task automatic test_tie();
        do_reset();
        we_a = 1'b0; we_b = 1'b0; addr_a = 32'h0; addr_b = 32'h0;
        step(); req_a = 1'b1; req_b = 1'b1; #1;
        n_cmp++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin n_fail++; $display("FAIL tie1_gnt got %b%b want 10", gnt_a, gnt_b); end
        step(); req_a = 1'b0; #1;
        n_cmp++; if (gnt_b !== 1'b0) begin n_fail++; $display("FAIL tie_access_gnt_b got %b want 0", gnt_b); end
        step(); #1;
        n_cmp++; if (gnt_b !== 1'b1 || rvalid_a !== 1'b1) begin n_fail++; $display("FAIL tie_b_gnt got gnt_b=%b rv_a=%b want 1 1", gnt_b, rvalid_a); end
        step(); req_a = 1'b1; req_b = 1'b1; #1;
        step(); #1;
        n_cmp++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || rvalid_b !== 1'b1) begin n_fail++; $display("FAIL tie2 got gnt=%b%b rv_b=%b want 10 1", gnt_a, gnt_b, rvalid_b); end
        step(); req_a = 1'b0; req_b = 1'b0;
        step(); step();
    endtask

    task automatic test_write();
        mem[2] = 32'h00000010;
        step(); req_b = 1'b1; we_b = 1'b1; addr_b = 32'h8; wdata_b = 32'hAABBCCDD; be_b = 4'b0101; #1;
        n_cmp++; if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin n_fail++; $display("FAIL wr_gnt got %b%b want 01", gnt_a, gnt_b); end
        step(); req_b = 1'b0; #1;
        n_cmp++; if (mem_we !== 1'b1 || mem_waddr !== 32'h8) begin n_fail++; $display("FAIL wr_access got we=%b waddr=%h want 1 00000008", mem_we, mem_waddr); end
        n_cmp++; if (mem_wdata !== 32'h00BB00DD) begin n_fail++; $display("FAIL wr_merge got %h want 00bb00dd", mem_wdata); end
        step(); #1;
        n_cmp++; if (rvalid_b !== 1'b1 || err_b !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_done got rv=%b err=%b we=%b want 1 0 0", rvalid_b, err_b, mem_we); end
        n_cmp++; if (mem[2] !== 32'h00BB00DD) begin n_fail++; $display("FAIL wr_mem got %h want 00bb00dd", mem[2]); end
        // Zero byte enables: write completes but the word is unchanged.
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h8; wdata_a = 32'hFFFFFFFF; be_a = 4'b0000; #1;
        n_cmp++; if (gnt_a !== 1'b1) begin n_fail++; $display("FAIL be0_gnt got %b want 1", gnt_a); end
        step(); req_a = 1'b0; #1;
        n_cmp++; if (mem_wdata !== 32'h00BB00DD) begin n_fail++; $display("FAIL be0_merge got %h want 00bb00dd", mem_wdata); end
        step(); #1;
        n_cmp++; if (rvalid_a !== 1'b1 || mem[2] !== 32'h00BB00DD) begin n_fail++; $display("FAIL be0_done got rv=%b mem=%h want 1 00bb00dd", rvalid_a, mem[2]); end
        // Read back through port B (low address bits must be ignored).
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'hB; #1;
        step(); req_b = 1'b0;
        step(); #1;
        n_cmp++; if (rvalid_b !== 1'b1 || rdata_b !== 32'h00BB00DD) begin n_fail++; $display("FAIL wr_readback got rv=%b rdata=%h want 1 00bb00dd", rvalid_b, rdata_b); end
        step();
    endtask

    task automatic test_out_of_range();
        mem[1023] = 32'h12345678;
        step(); req_a = 1'b1; we_a = 1'b0; addr_a = 32'hFFC;
        step(); req_a = 1'b0;
        step(); #1;
        n_cmp++; if (rvalid_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'h12345678) begin n_fail++; $display("FAIL last_word got rv=%b err=%b rdata=%h want 1 0 12345678", rvalid_a, err_a, rdata_a); end
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h1000;
        step(); req_a = 1'b0; #1;
        n_cmp++; if (mem_we !== 1'b0 || mem_raddr !== 32'h1000) begin n_fail++; $display("FAIL oor_rd_access got we=%b raddr=%h want 0 00001000", mem_we, mem_raddr); end
        step(); #1;
        n_cmp++; if (rvalid_a !== 1'b1 || err_a !== 1'b1 || rdata_a !== 32'h0) begin n_fail++; $display("FAIL oor_rd got rv=%b err=%b rdata=%h want 1 1 0", rvalid_a, err_a, rdata_a); end
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h1000; wdata_a = 32'h55; be_a = 4'hF;
        step(); req_a = 1'b0; #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL oor_wr_we got %b want 0", mem_we); end
        step(); #1;
        n_cmp++; if (rvalid_a !== 1'b1 || err_a !== 1'b1 || mem[0] === 32'h55) begin n_fail++; $display("FAIL oor_wr got rv=%b err=%b mem0=%h want 1 1 !=55", rvalid_a, err_a, mem[0]); end
        step(); #1;
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL err_pulse got %b want 0", err_a); end
    endtask

    task automatic test_reset_in_access();
        mem[0] = 32'hCAFE0000;
        step(); req_a = 1'b1; we_a = 1'b1; addr_a = 32'h0; wdata_a = 32'h1; be_a = 4'hF; #1;
        n_cmp++; if (gnt_a !== 1'b1) begin n_fail++; $display("FAIL rstacc_gnt got %b want 1", gnt_a); end
        step(); req_a = 1'b0; rst = 1'b1; #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstacc_we got %b want 0", mem_we); end
        step(); rst = 1'b0; #1;
        n_cmp++; if (rvalid_a !== 1'b0) begin n_fail++; $display("FAIL rstacc_rv1 got %b want 0", rvalid_a); end
        step(); #1;
        n_cmp++; if (rvalid_a !== 1'b0 || mem[0] !== 32'hCAFE0000) begin n_fail++; $display("FAIL rstacc_rv2 got rv=%b mem0=%h want 0 cafe0000", rvalid_a, mem[0]); end
    endtask

    task automatic test_back_to_back();
        int grants = 0;
        step(); req_a = 1'b1; we_a = 1'b0; addr_a = 32'h4; req_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (gnt_a === 1'b1) grants++;
            n_cmp++; if (gnt_a !== (i % 2 == 0) || gnt_b !== 1'b0) begin n_fail++; $display("FAIL b2b_gnt cyc %0d got %b%b want %b0", i, gnt_a, gnt_b, (i % 2 == 0)); end
            n_cmp++; if (rvalid_a !== (i % 2 == 0 && i > 0)) begin n_fail++; $display("FAIL b2b_rvalid cyc %0d got %b want %b", i, rvalid_a, (i % 2 == 0 && i > 0)); end
            step();
        end
        req_a = 1'b0; #1;
        n_cmp++; if (rvalid_a !== 1'b1 || rdata_a !== 32'h1) begin n_fail++; $display("FAIL b2b_last got rv=%b rdata=%h want 1 00000001", rvalid_a, rdata_a); end
        n_cmp++; if (grants !== 10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", grants); end
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_read();
        test_tie();
        test_write();
        test_out_of_range();
        test_reset_in_access();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
